// File: rtl/can_rx_frame_buffer.sv
// CAN RX frame buffer: packs the controller's byte stream into 64-bit frames and queues them in a FWFT FIFO.
// Optional macro CAN_RX_TIMESTAMP_EN adds a free-running cycle counter and the out_ts port.
module can_rx_frame_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [7:0]            in_data,
  input  logic [28:0]           in_id,
  input  logic                  in_ide,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [63:0]           out_data,
  output logic [3:0]            out_len,
  output logic [28:0]           out_id,
  output logic                  out_ide,
`ifdef CAN_RX_TIMESTAMP_EN
  output logic [31:0]           out_ts,
`endif
  output logic [DEPTH_LOG2:0]   count,
  output logic                  drop,
  output logic [CNT_W-1:0]      overflow_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  len;
    logic [28:0] id;
    logic        ide;
`ifdef CAN_RX_TIMESTAMP_EN
    logic [31:0] ts;
`endif
  } entry_t;

  logic [63:0]      acc_r, acc_s;
  logic [3:0]       idx_r;
  logic [5:0]       shamt_s;
  logic             commit_s, wr_en_s, pop_s, full_s;
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s, count_nxt_s, count_r;
  entry_t           mem_r [DEPTH];
  entry_t           new_s, head_r, head_nxt_s;
  logic             out_valid_r, drop_r;
  logic [CNT_W-1:0] ovf_r;
`ifdef CAN_RX_TIMESTAMP_EN
  logic [31:0]      ts_cnt_r, ts_hold_r;
`endif

  // Byte placement into the accumulator and the entry that a commit would push
  always_comb begin
    shamt_s = 6'd56 - {idx_r[2:0], 3'b000};
    acc_s   = acc_r;
    if (in_valid && (idx_r < 4'd8)) begin
      acc_s = acc_r | ({56'd0, in_data} << shamt_s);
    end else begin
      acc_s = acc_r;
    end
    commit_s     = in_valid & in_last;
    new_s        = '0;
    new_s.data   = acc_s;
    new_s.len    = (idx_r < 4'd8) ? (idx_r + 4'd1) : 4'd8;
    new_s.id     = in_id;
    new_s.ide    = in_ide;
`ifdef CAN_RX_TIMESTAMP_EN
    new_s.ts     = (idx_r == 4'd0) ? ts_cnt_r : ts_hold_r;
`endif
  end

  // FIFO pointer arithmetic and next head entry (bypass when writing into an empty slot at the head)
  always_comb begin
    full_s       = ((wr_ptr_r ^ rd_ptr_r) == {1'b1, {DEPTH_LOG2{1'b0}}});
    wr_en_s      = commit_s & ~full_s;
    pop_s        = out_valid_r & out_ready;
    wr_ptr_nxt_s = wr_ptr_r + {{DEPTH_LOG2{1'b0}}, wr_en_s};
    rd_ptr_nxt_s = rd_ptr_r + {{DEPTH_LOG2{1'b0}}, pop_s};
    count_nxt_s  = wr_ptr_nxt_s - rd_ptr_nxt_s;
    head_nxt_s   = '0;
    if (count_nxt_s == {PW{1'b0}}) begin
      head_nxt_s = '0;
    end else if (wr_en_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_nxt_s = new_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[DEPTH_LOG2-1:0]];
    end
  end

  // Frame storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= new_s;
    end
  end

  // Assembly state, FIFO pointers and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_r       <= 64'd0;
      idx_r       <= 4'd0;
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {PW{1'b0}};
      head_r      <= '0;
      out_valid_r <= 1'b0;
      drop_r      <= 1'b0;
      ovf_r       <= {CNT_W{1'b0}};
    end else begin
      if (commit_s) begin
        acc_r <= 64'd0;
        idx_r <= 4'd0;
      end else if (in_valid && (idx_r < 4'd8)) begin
        acc_r <= acc_s;
        idx_r <= idx_r + 4'd1;
      end else begin
        acc_r <= acc_r;
        idx_r <= idx_r;
      end
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      head_r      <= head_nxt_s;
      out_valid_r <= (count_nxt_s != {PW{1'b0}});
      drop_r      <= commit_s & full_s;
      if (commit_s && full_s && (ovf_r != {CNT_W{1'b1}})) begin
        ovf_r <= ovf_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

`ifdef CAN_RX_TIMESTAMP_EN
  // Free-running cycle counter; latched at each frame's first byte
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts_cnt_r  <= 32'd0;
      ts_hold_r <= 32'd0;
    end else begin
      ts_cnt_r <= ts_cnt_r + 32'd1;
      if (in_valid && (idx_r == 4'd0)) begin
        ts_hold_r <= ts_cnt_r;
      end else begin
        ts_hold_r <= ts_hold_r;
      end
    end
  end
  assign out_ts = head_r.ts;
`endif

  assign out_valid    = out_valid_r;
  assign out_data     = head_r.data;
  assign out_len      = head_r.len;
  assign out_id       = head_r.id;
  assign out_ide      = head_r.ide;
  assign count        = count_r;
  assign drop         = drop_r;
  assign overflow_cnt = ovf_r;

endmodule

// File: tb/tb_can_rx_frame_buffer.sv
// Self-checking bench for can_rx_frame_buffer (DEPTH_LOG2=2) using a scoreboard queue of expected frames.
module tb_can_rx_frame_buffer;

  localparam int DL = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, in_ide = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic [28:0] in_id = 29'd0;
  logic        out_valid, out_ide, drop;
  logic [63:0] out_data;
  logic [3:0]  out_len;
  logic [28:0] out_id;
  logic [DL:0] count;
  logic [15:0] overflow_cnt;
`ifdef CAN_RX_TIMESTAMP_EN
  logic [31:0] out_ts;
`endif

  can_rx_frame_buffer #(.DEPTH_LOG2(DL), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_id(in_id), .in_ide(in_ide),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_len(out_len),
    .out_id(out_id), .out_ide(out_ide),
`ifdef CAN_RX_TIMESTAMP_EN
    .out_ts(out_ts),
`endif
    .count(count), .drop(drop), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  len;
    logic [28:0] id;
    logic        ide;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          mcount = 0;
  int          mk = 0;
  logic [63:0] macc = 64'd0;
  logic [15:0] movf = 16'd0;
  logic        mdrop = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: compare head against scoreboard, advance the model, clock, then check status outputs
  task automatic tick();
    bit   pop, com, full;
    exp_t e;
    if (!rstn) begin
      q.delete(); mcount = 0; mk = 0; macc = 64'd0; movf = 16'd0;
    end
    if (mcount != 0) begin
      chk("head_data", out_data, q[0].d);
      chk("head_len",  {60'd0, out_len}, {60'd0, q[0].len});
      chk("head_id",   {35'd0, out_id}, {35'd0, q[0].id});
      chk("head_ide",  {63'd0, out_ide}, {63'd0, q[0].ide});
    end
    pop   = rstn && (mcount != 0) && out_ready;
    com   = rstn && in_valid && in_last;
    full  = (mcount == DEPTH);
    mdrop = 1'b0;
    if (rstn && in_valid && mk < 8) begin
      macc[63-8*mk -: 8] = in_data;
      mk++;
    end
    if (pop) void'(q.pop_front());
    if (com) begin
      e.d = macc; e.len = mk[3:0]; e.id = in_id; e.ide = in_ide;
      if (full) begin
        mdrop = 1'b1;
        if (movf != 16'hFFFF) movf++;
      end else begin
        q.push_back(e);
      end
      macc = 64'd0; mk = 0;
    end
    mcount = mcount + ((com && !full) ? 1 : 0) - (pop ? 1 : 0);
    @(posedge clk); #1;
    chk("count", {61'd0, count}, mcount);
    chk("out_valid", {63'd0, out_valid}, {63'd0, (mcount != 0)});
    chk("drop", {63'd0, drop}, {63'd0, mdrop});
    chk("overflow_cnt", {48'd0, overflow_cnt}, {48'd0, movf});
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    in_valid = 1'b1; in_data = b; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_data"}, out_data, 64'd0);
    chk({tag, "_len"}, {60'd0, out_len}, 64'd0);
    chk({tag, "_id"}, {35'd0, out_id}, 64'd0);
    chk({tag, "_ide_drop"}, {62'd0, out_ide, drop}, 64'd0);
    chk({tag, "_cnt"}, {45'd0, count, overflow_cnt}, 64'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk_zero("rst");
    idle(2);
    chk_zero("rst_hold");
    rstn = 1'b1;

    // 8-byte frame with consumer ready
    out_ready = 1'b1;
    in_id = 29'h123; in_ide = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(8'h11 * i), i == 8);
    chk("t1_data", out_data, 64'h1122334455667788);
    chk("t1_len", {60'd0, out_len}, 64'd8);
    idle(2);

    // 3-byte frame with gaps, extended ID
    in_id = 29'h12345678; in_ide = 1'b1;
    send(8'hAA, 1'b0); idle(2);
    send(8'hBB, 1'b0); idle(2);
    out_ready = 1'b0;
    send(8'hCC, 1'b1);
    chk("t2_data", out_data, 64'hAABBCC0000000000);
    chk("t2_len", {60'd0, out_len}, 64'd3);
    idle(2);
    out_ready = 1'b1; idle(2);

    // Overflow: 5 one-byte frames with consumer stalled
    out_ready = 1'b0; in_ide = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_id = 29'(i);
      send(8'(i), 1'b1);
    end
    chk("t3_count", {61'd0, count}, 64'd4);
    chk("t3_ovf", {48'd0, overflow_cnt}, 64'd1);
    idle(2);
    out_ready = 1'b1; idle(5);

    // Full FIFO: commit coincides with a pop, frame still dropped
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_id = 29'(16 + i);
      send(8'(8'h40 + i), 1'b1);
    end
    out_ready = 1'b1;
    send(8'h99, 1'b1);
    chk("t4_count", {61'd0, count}, 64'd3);
    chk("t4_ovf", {48'd0, overflow_cnt}, 64'd2);
    idle(4);

    // Two stored, simultaneous commit and pop
    out_ready = 1'b0;
    send(8'h51, 1'b1); send(8'h52, 1'b1);
    out_ready = 1'b1;
    send(8'h53, 1'b1);
    chk("t5_count", {61'd0, count}, 64'd2);
    idle(3);

    // Over-long frame: extra bytes ignored, len saturates at 8
    for (int i = 0; i < 10; i++) send(8'(8'hA0 + i), i == 9);
    idle(2);

    // Reset mid-frame, then a 2-byte frame
    for (int i = 0; i < 4; i++) send(8'(8'hE0 + i), 1'b0);
    rstn = 1'b0;
    #1;
    chk_zero("mid_rst");
    tick(); tick();
    rstn = 1'b1;
    out_ready = 1'b0;
    send(8'h01, 1'b0); send(8'h02, 1'b1);
    chk("t6_data", out_data, 64'h0102000000000000);
    chk("t6_len", {60'd0, out_len}, 64'd2);
    out_ready = 1'b1; idle(3);

    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_rx_frame_buffer.md
Name: can_rx_frame_buffer

Overview:
- Sink for the CAN controller's unbuffered user RX byte stream (valid/last/data/id/ide, one byte per cycle, no back-pressure).
- Reassembles each frame's bytes into a single 64-bit word and stores it, with ID, IDE and length, in a frame FIFO.
- Presents stored frames on a valid/ready pop interface for the bus-bridge or CPU-side reader.
- Counts frames lost to FIFO overflow.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 frames; legal range 1..8.
- CNT_W, 16: width of the overflow counter.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset; 1 while working
- in_valid  in  1  byte strobe from the CAN controller
- in_last  in  1  marks the last byte of a frame; qualified by in_valid
- in_data  in  8  data byte
- in_id  in  29  frame ID; sampled with the last byte
- in_ide  in  1  1 = 29-bit ID, 0 = 11-bit ID; sampled with the last byte
- out_valid  out  1  head FIFO entry available
- out_ready  in  1  consumer pops when out_valid & out_ready
- out_data  out  64  frame payload; byte 0 in [63:56], unused bytes zero
- out_len  out  4  payload byte count, 1..8
- out_id  out  29  frame ID
- out_ide  out  1  frame IDE
- count  out  DEPTH_LOG2+1  frames currently stored
- drop  out  1  one-cycle pulse when a completed frame is discarded
- overflow_cnt  out  CNT_W  saturating count of discarded frames

Behaviour:
Reset:
- Every output is 0; the FIFO is empty.
- The assembly state is cleared: accumulator 0, byte index 0.
- Reset mid-frame discards the partial frame. The next in_valid starts a new frame at byte 0.

Assembly:
- A frame starts at the first in_valid after reset or after a byte with in_last.
- Byte index k runs 0..7. Byte k is written to accumulator bits [63-8k -: 8], and the index increments.
- Bytes beyond the 8th are ignored; the index saturates at 8 and out_len reports 8.
- in_valid low cycles inside a frame are legal gaps and do not end the frame.
- On in_valid & in_last, the frame is committed with len = min(k+1, 8).
  - The accumulator, including the final byte, is pushed.
  - in_id and in_ide are taken from that same cycle.
  - The accumulator and index are cleared in the same cycle.
- in_last without in_valid is ignored.

FIFO:
- Circular buffer with DEPTH_LOG2+1-bit read and write pointers.
- full when the pointers are equal except for the MSB; empty when the pointers are fully equal. Pointers wrap naturally.
- Commit with the FIFO not full: the entry is written and out_valid rises the next cycle if the FIFO was empty (1-cycle latency).
- Commit with the FIFO full:
  - Fullness is taken from the pre-cycle state, so a same-cycle pop does not rescue the frame.
  - The frame is discarded and drop pulses for 1 cycle on the next edge.
  - overflow_cnt increments and saturates at all-ones.
- Pop on out_valid & out_ready: the read pointer advances and the next entry appears the following cycle (first-word-fall-through).
- While out_valid=1 and out_ready=0, out_data, out_len, out_id and out_ide stay stable.
- Simultaneous commit and pop with the FIFO not full: both occur and count is unchanged.
- count is updated registered, +1 on commit, −1 on pop, net 0 when both occur.

Optional Feature:
- Macro CAN_RX_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter is added; it resets to 0 and wraps.
  - The counter value at a frame's first byte is stored with the entry.
  - The value is output on the added port out_ts (out, 32), which follows the same stability rules as out_data.
- Undefined: no counter, no out_ts port, and entry width is unchanged.

Test Plan:
- 8-byte frame 11 22 33 44 55 66 77 88, id=0x123, ide=0, with out_ready=1.
  -> One cycle after last: out_valid=1, out_data=0x1122334455667788, out_len=8, out_id=0x123, out_ide=0; count returns to 0 after the pop.
- 3-byte frame AA BB CC with 2-cycle gaps between bytes, id=0x12345678, ide=1.
  -> out_data=0xAABBCC0000000000, out_len=3, out_ide=1.
- DEPTH_LOG2=2, 5 one-byte frames, out_ready=0.
  -> count=4; 5th frame dropped; drop pulses once; overflow_cnt=1.
  -> Popping then yields frames 1..4 in order.
- FIFO full, commit in the same cycle as a pop.
  -> Frame dropped and overflow_cnt increments; count goes 4→3.
- FIFO holding 2, commit and pop in the same cycle.
  -> count stays 2; order preserved.
- rstn pulsed low after 4 bytes of a frame, then a 2-byte frame 01 02.
  -> All outputs 0 during reset; the next entry has out_data=0x0102000000000000, out_len=2.
